// File: rtl/vector_fifo_ctl.sv
// Vector word FIFO with occupancy, threshold flags, flush,
// sticky error flags and a show-ahead or registered read port.
module vector_fifo_ctl #(
  parameter int WIDTH     = 248,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int OUT_REG   = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_fifo_full,
  output logic                     o_fifo_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow,
  input  logic                     i_clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             rd_acc;
  logic             wr_acc;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;

  // Wrap bit in the MSB makes full/empty unambiguous.
  assign count   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);

  assign rd_acc  = i_read & ~empty;
  assign wr_acc  = i_write & (~full | rd_acc);
  assign ovf_set = i_write & ~wr_acc & ~i_flush;
  assign unf_set = i_read & ~rd_acc & ~i_flush;

  assign o_count        = count;
  assign o_fifo_full    = full;
  assign o_fifo_empty   = empty;
  assign o_almost_full  = (count >= PW'(AFULL_TH));
  assign o_almost_empty = (count <= PW'(AEMPTY_TH));
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !i_flush) mem[wr_addr] <= i_data;
  end

  // A set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (i_clr_err) ovf_q <= 1'b0;
      if (unf_set)        unf_q <= 1'b1;
      else if (i_clr_err) unf_q <= 1'b0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (i_flush) begin
          valid_q <= 1'b0;
        end else if (rd_acc) begin
          data_q  <= mem[rd_addr];
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign o_data  = data_q;
      assign o_valid = valid_q;
    end else begin : g_sa
      assign o_data  = mem[rd_addr];
      assign o_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_vector_fifo_ctl.sv
// Scoreboard bench: show-ahead and registered instances
// driven in lockstep and checked against a queue model.
module tb_vector_fifo_ctl;

  localparam int W   = 248;
  localparam int D   = 16;
  localparam int AF  = 12;
  localparam int AE  = 4;
  localparam int CW  = $clog2(D) + 1;

  logic         clk = 1'b0;
  logic         rstn;
  logic         i_flush, i_write, i_read, i_clr_err;
  logic [W-1:0] i_data;

  logic [W-1:0]  sa_data, rg_data;
  logic          sa_valid, rg_valid;
  logic          sa_full, rg_full, sa_empty, rg_empty;
  logic          sa_af, rg_af, sa_ae, rg_ae;
  logic [CW-1:0] sa_count, rg_count;
  logic          sa_ovf, rg_ovf, sa_unf, rg_unf;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];
  logic         m_ovf, m_unf, m_v1;
  logic [W-1:0] last1;

  always #5 clk = ~clk;

  vector_fifo_ctl #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(AF),
    .AEMPTY_TH(AE), .OUT_REG(0)
  ) u_sa (
    .clk(clk), .rstn(rstn), .i_flush(i_flush),
    .i_write(i_write), .i_data(i_data), .i_read(i_read),
    .o_data(sa_data), .o_valid(sa_valid),
    .o_fifo_full(sa_full), .o_fifo_empty(sa_empty),
    .o_almost_full(sa_af), .o_almost_empty(sa_ae),
    .o_count(sa_count), .o_overflow(sa_ovf),
    .o_underflow(sa_unf), .i_clr_err(i_clr_err)
  );

  vector_fifo_ctl #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(AF),
    .AEMPTY_TH(AE), .OUT_REG(1)
  ) u_rg (
    .clk(clk), .rstn(rstn), .i_flush(i_flush),
    .i_write(i_write), .i_data(i_data), .i_read(i_read),
    .o_data(rg_data), .o_valid(rg_valid),
    .o_fifo_full(rg_full), .o_fifo_empty(rg_empty),
    .o_almost_full(rg_af), .o_almost_empty(rg_ae),
    .o_count(rg_count), .o_overflow(rg_ovf),
    .o_underflow(rg_unf), .i_clr_err(i_clr_err)
  );

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Reference model: a FIFO of words with the accept rules.
  always @(posedge clk or negedge rstn) begin
    int  sz;
    bit  rd, wr;
    if (!rstn) begin
      model_q.delete();
      sb0.delete();
      sb1.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
      m_v1  <= 1'b0;
      last1 <= '0;
    end else if (i_flush) begin
      model_q.delete();
      sb0.delete();
      sb1.delete();
      m_v1 <= 1'b0;
      if (i_clr_err) begin
        m_ovf <= 1'b0;
        m_unf <= 1'b0;
      end
    end else begin
      sz = model_q.size();
      rd = i_read && (sz > 0);
      wr = i_write && ((sz < D) || rd);
      if (rd) void'(model_q.pop_front());
      if (wr) begin
        model_q.push_back(i_data);
        sb0.push_back(i_data);
        sb1.push_back(i_data);
      end
      m_v1 <= rd;
      if (i_write && !wr) m_ovf <= 1'b1;
      else if (i_clr_err) m_ovf <= 1'b0;
      if (i_read && !rd) m_unf <= 1'b1;
      else if (i_clr_err) m_unf <= 1'b0;
    end
  end

  // Status monitor, both instances.
  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    chk("count_sa", sa_count, sz);
    chk("count_rg", rg_count, sz);
    chk("full_sa", sa_full, sz == D);
    chk("full_rg", rg_full, sz == D);
    chk("empty_sa", sa_empty, sz == 0);
    chk("empty_rg", rg_empty, sz == 0);
    chk("afull", sa_af, sz >= AF);
    chk("aempty", rg_ae, sz <= AE);
    chk("ovf_sa", sa_ovf, m_ovf);
    chk("unf_rg", rg_unf, m_unf);
    chk("ovf_rg", rg_ovf, m_ovf);
    chk("unf_sa", sa_unf, m_unf);
    chk("valid_sa", sa_valid, sz != 0);
    chk("valid_rg", rg_valid, m_v1);
  end

  // Show-ahead data: head word seen when a read will be taken.
  always @(negedge clk) begin
    if (rstn && sa_valid && i_read && !i_flush) begin
      chk("sb0_nonempty", sb0.size() != 0, 1);
      if (sb0.size() != 0) chk("data_sa", sa_data, sb0.pop_front());
    end
  end

  // Registered data: word appears one cycle after the read.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rstn && rg_valid) begin
      chk("sb1_nonempty", sb1.size() != 0, 1);
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        chk("data_rg", rg_data, e);
        last1 <= e;
      end
    end else if (rstn) begin
      chk("hold_rg", rg_data, last1);
    end
  end

  task automatic cyc(input logic fl, input logic wr,
                     input logic rd, input logic clr,
                     input logic [W-1:0] d);
    i_flush   = fl;
    i_write   = wr;
    i_read    = rd;
    i_clr_err = clr;
    i_data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, sa_count, 0);
    chk({tag, "_empty"}, rg_empty, 1);
    chk({tag, "_full"}, sa_full, 0);
    chk({tag, "_ae"}, sa_ae, 1);
    chk({tag, "_af"}, rg_af, 0);
    chk({tag, "_ovf"}, sa_ovf, 0);
    chk({tag, "_unf"}, rg_unf, 0);
    chk({tag, "_vsa"}, sa_valid, 0);
    chk({tag, "_vrg"}, rg_valid, 0);
    chk({tag, "_drg"}, rg_data, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int pw, pr;
    rstn = 1'b0;
    i_flush = 0; i_write = 0; i_read = 0;
    i_clr_err = 0; i_data = '0;
    #3;
    chk_reset("rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(0, 0, 0, 0, '0);

    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 0, W'(i));
      chk("fill_count", sa_count, i);
      chk("fill_af", sa_af, i >= 12);
    end
    chk("fill_full", sa_full, 1);
    cyc(0, 1, 0, 0, W'('h99));
    chk("ovf_set", sa_ovf, 1);
    chk("ovf_count", rg_count, 16);
    chk("ovf_head", sa_data, 1);
    cyc(0, 0, 0, 1, '0);
    chk("ovf_clr", sa_ovf, 0);

    cyc(0, 1, 1, 0, W'('hAA));
    chk("rw_full_count", sa_count, 16);
    chk("rw_full_ovf", sa_ovf, 0);
    chk("rw_full_head", sa_data, 2);
    repeat (16) cyc(0, 0, 1, 0, '0);
    chk("drain_empty", sa_empty, 1);
    cyc(0, 0, 0, 0, '0);

    cyc(0, 1, 1, 0, W'('h55));
    chk("nobypass_unf", sa_unf, 1);
    chk("nobypass_count", sa_count, 1);
    chk("nobypass_head", sa_data, W'('h55));
    cyc(0, 0, 0, 1, '0);
    chk("unf_clr", rg_unf, 0);
    cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, '0);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, W'(100 + i));
    for (int k = 0; k < 40; k++) begin
      cyc(0, 1, 1, 0, W'(103 + k));
      chk("wrap_count", sa_count, 3);
      chk("wrap_ae", sa_ae, 1);
    end
    repeat (3) cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 0, 0, '0);

    cyc(0, 1, 0, 0, W'('h7));
    cyc(0, 0, 1, 0, '0);
    chk("reg_valid1", rg_valid, 1);
    chk("reg_data1", rg_data, W'('h7));
    cyc(0, 0, 0, 0, '0);
    chk("reg_valid2", rg_valid, 0);
    chk("reg_data2", rg_data, W'('h7));

    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, rnd_word());
    chk("pre_flush", sa_count, 9);
    cyc(1, 1, 0, 0, rnd_word());
    chk("flush_count", sa_count, 0);
    chk("flush_empty", rg_empty, 1);
    chk("flush_ovf", sa_ovf, 0);
    chk("flush_hold", rg_data, W'('h7));

    for (int ph = 0; ph < 3; ph++) begin
      pw = 70 - 20 * ph;
      pr = 30 + 20 * ph;
      for (int n = 0; n < 600; n++) begin
        cyc(($urandom_range(49) == 0),
            ($urandom_range(99) < pw),
            ($urandom_range(99) < pr),
            ($urandom_range(19) == 0),
            rnd_word());
      end
    end

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, rnd_word());
    i_write = 1'b1;
    i_read  = 1'b1;
    i_data  = rnd_word();
    #1;
    rstn = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(0, 0, 0, 0, '0);
    cyc(0, 1, 0, 0, W'('hBEEF));
    chk("post_rst_count", sa_count, 1);
    chk("post_rst_head", sa_data, W'('hBEEF));
    cyc(0, 0, 1, 0, '0);
    chk("post_rst_rg", rg_data, W'('hBEEF));
    cyc(0, 0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
